uart_byte_tx: RTL and testbench

- Byte-level UART transmit controller; sits directly downstream of the TX baud-rate generator.
- Accepts a byte plus a one-cycle send request and asserts Byte_En to start the generator.
- Consumes the generator's one-cycle Bps_Clk pulses (one per bit period) and serialises start, data LSB-first, optional parity and stop bits onto Rs232_Tx.
- Returns a one-cycle Tx_Done, which the generator also uses to stop.

---
 rtl/uart_byte_tx_pkg.sv | 10 +
 rtl/uart_byte_tx.sv | 80 ++++++++
 tb/tb_uart_byte_tx.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/uart_byte_tx_pkg.sv
// uart_byte_tx_pkg: parity modes, state encoding and parity helper shared by the UART TX/RX sides
package uart_byte_tx_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} uart_state_e;
  function automatic logic parity_of(input logic [7:0] d, input logic odd);
    return odd ? ~^d : ^d;
  endfunction
endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: serialises a byte as start, LSB-first data, optional parity and stop bits paced by Bps_Clk
module uart_byte_tx
  import uart_byte_tx_pkg::*;
#(
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Send_En,
  input  logic [7:0] Data_Byte,
  input  logic       Bps_Clk,
  output logic       Byte_En,
  output logic       Rs232_Tx,
  output logic       Tx_Done,
  output logic       Uart_state
);
  localparam bit HAS_PAR = (PARITY == PAR_ODD) || (PARITY == PAR_EVEN);
  localparam int NSTOP = (STOP_BITS == 2) ? 2 : 1;
  localparam logic [3:0] N = 4'(9 + (HAS_PAR ? 1 : 0) + NSTOP);
  uart_state_e state, state_d;
  logic [3:0] bit_cnt, cnt_d;
  logic [7:0] data_r, data_d;
  logic par_r, par_d, tx_d, ben_d, done_d, frame_bit;
  logic [2:0] idx;
  assign idx = 3'(bit_cnt - 4'd1);
  assign frame_bit = (bit_cnt == 4'd0) ? 1'b0 :
                     (bit_cnt <= 4'd8) ? data_r[idx] :
                     (HAS_PAR && bit_cnt == 4'd9) ? par_r : 1'b1;
  assign Uart_state = (state == SEND);
  // next-state: accept a byte in IDLE, step one frame bit per Bps_Clk in SEND, finish on pulse N+1
  always_comb begin
    state_d = state;
    cnt_d   = bit_cnt;
    data_d  = data_r;
    par_d   = par_r;
    tx_d    = Rs232_Tx;
    ben_d   = Byte_En;
    done_d  = 1'b0;
    if (state == IDLE) begin
      if (Send_En) begin
        state_d = SEND;
        data_d  = Data_Byte;
        par_d   = parity_of(Data_Byte, PARITY == PAR_ODD);
        ben_d   = 1'b1;
      end
    end else if (Bps_Clk) begin
      if (bit_cnt == N) begin
        state_d = IDLE;
        cnt_d   = 4'd0;
        tx_d    = 1'b1;
        ben_d   = 1'b0;
        done_d  = 1'b1;
      end else begin
        cnt_d = bit_cnt + 4'd1;
        tx_d  = frame_bit;
      end
    end
  end
  // all outputs are registered so nothing combinational reaches Byte_En, Tx_Done or the line
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state    <= IDLE;
      bit_cnt  <= 4'd0;
      data_r   <= 8'd0;
      par_r    <= 1'b0;
      Rs232_Tx <= 1'b1;
      Byte_En  <= 1'b0;
      Tx_Done  <= 1'b0;
    end else begin
      state    <= state_d;
      bit_cnt  <= cnt_d;
      data_r   <= data_d;
      par_r    <= par_d;
      Rs232_Tx <= tx_d;
      Byte_En  <= ben_d;
      Tx_Done  <= done_d;
    end
  end
endmodule

// File: tb/tb_uart_byte_tx.sv
// tb_uart_byte_tx: four parity/stop configurations driven by a 434-clock baud generator model
module tb_uart_byte_tx;
  localparam int BPS = 434;
  localparam int TMO = 1000;
  typedef struct {
    int          dut;
    logic [7:0]  data;
    logic [11:0] frame;
    int          n;
  } vec_t;
  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  logic [3:0] send_en = '0;
  logic [3:0] inj = '0;
  logic [3:0] gen = '0;
  logic [3:0] bps, ben, tx, done, busy;
  logic [7:0] data [4];
  int bcnt [4];
  int done_cnt [4];
  int exp_done [4];
  int checks = 0;
  int errors = 0;
  vec_t vt [9];
  always #10 Clk = ~Clk;
  assign bps = gen | inj;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_byte_tx #(.PARITY(g == 1 ? 1 : g == 2 ? 2 : 0), .STOP_BITS(g == 3 ? 2 : 1)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Send_En(send_en[g]), .Data_Byte(data[g]), .Bps_Clk(bps[g]),
      .Byte_En(ben[g]), .Rs232_Tx(tx[g]), .Tx_Done(done[g]), .Uart_state(busy[g]));
  end
  always @(posedge Clk)
    for (int j = 0; j < 4; j++) begin
      bcnt[j] <= (!ben[j] || bcnt[j] == BPS - 1) ? 0 : bcnt[j] + 1;
      gen[j]  <= ben[j] && bcnt[j] == BPS - 1;
    end
  always @(negedge Clk)
    for (int j = 0; j < 4; j++) if (done[j]) done_cnt[j]++;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask
  task automatic send(input int i, input logic [7:0] d);
    send_en[i] = 1'b1;
    data[i] = d;
    @(negedge Clk);
    send_en[i] = 1'b0;
    data[i] = 8'($urandom);
    chk("accept_ben", 32'(ben[i]), 1);
    chk("accept_busy", 32'(busy[i]), 1);
    chk("accept_line", 32'(tx[i]), 1);
    exp_done[i]++;
  endtask
  task automatic expect_frame(input int i, input logic [11:0] exp, input int n, input bit noise);
    logic [11:0] got;
    int cyc, bad;
    got = '0;
    bad = 0;
    for (int k = 0; k <= n; k++) begin
      cyc = 0;
      while (!bps[i] && cyc < TMO) begin
        if (tx[i] !== (k == 0 ? 1'b1 : exp[k-1]) || done[i] !== 1'b0 || ben[i] !== 1'b1 || busy[i] !== 1'b1) bad++;
        @(negedge Clk);
        cyc++;
      end
      if (!bps[i]) begin
        chk("pulse_timeout", 32'(bps[i]), 1);
        return;
      end
      if (noise && (k == 4 || k == n)) begin
        send_en[i] = 1'b1;
        data[i] = 8'h3C;
      end
      @(negedge Clk);
      send_en[i] = 1'b0;
      if (k < n) got[k] = tx[i];
    end
    chk("frame_bits", 32'(got), 32'(exp));
    chk("bit_hold", bad, 0);
    chk("done_pulse", 32'(done[i]), 1);
    chk("done_ben", 32'(ben[i]), 0);
    chk("done_busy", 32'(busy[i]), 0);
    chk("done_line", 32'(tx[i]), 1);
    @(negedge Clk);
    chk("done_one_cycle", 32'(done[i]), 0);
    chk("idle_busy", 32'(busy[i]), 0);
  endtask
  initial begin
    int cyc;
    vt = '{'{0, 8'h55, 12'h2AA, 10}, '{2, 8'hA7, 12'h74E, 11}, '{1, 8'hA7, 12'h54E, 11},
           '{3, 8'h00, 12'h600, 11}, '{0, 8'hFF, 12'h3FE, 10}, '{1, 8'h00, 12'h600, 11},
           '{2, 8'h00, 12'h400, 11}, '{3, 8'hC3, 12'h786, 11}, '{1, 8'h01, 12'h402, 11}};
    for (int i = 0; i < 4; i++) data[i] = 8'($urandom);
    repeat (3) @(negedge Clk);
    chk("rst_line", 32'(tx), 32'hF);
    chk("rst_ben", 32'(ben), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    Rst_n = 1'b1;
    @(negedge Clk);
    repeat (3) begin
      inj = 4'hF;
      @(negedge Clk);
      inj = 4'h0;
      @(negedge Clk);
      chk("idle_pulse_line", 32'(tx), 32'hF);
      chk("idle_pulse_done", 32'(done), 0);
      chk("idle_pulse_busy", 32'(busy), 0);
      repeat (5) @(negedge Clk);
    end
    for (int v = 0; v < 9; v++) begin
      send(vt[v].dut, vt[v].data);
      expect_frame(vt[v].dut, vt[v].frame, vt[v].n, 1'b0);
    end
    send(0, 8'hFF);
    expect_frame(0, 12'h3FE, 10, 1'b1);
    send(0, 8'h5A);
    expect_frame(0, 12'h2B4, 10, 1'b0);
    send(0, 8'h96);
    for (int p = 0; p < 5; p++) begin
      cyc = 0;
      do begin
        @(negedge Clk);
        cyc++;
      end while (!bps[0] && cyc < TMO);
    end
    chk("abort_wait_pulse", 32'(bps[0]), 1);
    @(negedge Clk);
    chk("abort_bit4_line", 32'(tx[0]), 0);
    Rst_n = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    exp_done[0]--;
    chk("abort_line", 32'(tx[0]), 1);
    chk("abort_ben", 32'(ben[0]), 0);
    chk("abort_busy", 32'(busy[0]), 0);
    chk("abort_done", 32'(done[0]), 0);
    repeat (600) @(negedge Clk);
    chk("abort_idle_line", 32'(tx[0]), 1);
    chk("abort_idle_busy", 32'(busy[0]), 0);
    send(0, 8'h96);
    expect_frame(0, 12'h32C, 10, 1'b0);
    repeat (5) @(negedge Clk);
    for (int i = 0; i < 4; i++) chk("done_count", done_cnt[i], exp_done[i]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
